// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Requester IDs double as grant-vector bit positions.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_IO  = 1'b1;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_DEF = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last winner loses a tie.
// History only advances when the enable marks a real grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic win;

  always_comb begin
    win = REQ_CPU;
    if (req_i[REQ_CPU] && req_i[REQ_IO]) begin
      win = ~last_q;
    end else if (req_i[REQ_IO]) begin
      win = REQ_IO;
    end
    gnt_o = {win, ~win} & {2{|req_i}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_IO;
    end else if (en_i && |req_i) begin
      last_q <= win;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between CPU and I/O requesters.
// One transaction in flight: IDLE -> ISSUE -> (WAIT) -> RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_off,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [31:0]       io_addr,
  input  logic [31:0]       io_off,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_done,
  output logic              io_err,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(RD_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [31:0]       sum_q, sum_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        arb_gnt;
  logic              arb_en;
  logic              oor;
  logic              issue;
  logic              resp;

  assign arb_en = (state_q == IDLE) && (cpu_req || io_req);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i ({io_req, cpu_req}),
    .gnt_o (arb_gnt)
  );

  // Any bit above the word-address range means the access misses memory.
  assign oor = |sum_q[31:ADDR_W];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    err_d       = err_q;
    sum_d       = sum_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (arb_en) begin
          owner_d = arb_gnt[REQ_IO];
          err_d   = 1'b0;
          state_d = ISSUE;
          if (arb_gnt[REQ_IO]) begin
            we_d    = io_we;
            sum_d   = io_addr + io_off;
            wdata_d = io_wdata;
          end else begin
            we_d    = cpu_we;
            sum_d   = cpu_addr + cpu_off;
            wdata_d = cpu_wdata;
          end
        end
      end
      ISSUE: begin
        if (oor) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = RESP;
          if (owner_q == REQ_IO) begin
            io_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= REQ_CPU;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      sum_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  assign issue = (state_q == ISSUE);
  assign resp  = (state_q == RESP);

  assign cpu_gnt  = issue && (owner_q == REQ_CPU);
  assign io_gnt   = issue && (owner_q == REQ_IO);
  assign cpu_done = resp && (owner_q == REQ_CPU);
  assign io_done  = resp && (owner_q == REQ_IO);
  assign cpu_err  = cpu_done && err_q;
  assign io_err   = io_done && err_q;

  assign cpu_rdata = cpu_rdata_q;
  assign io_rdata  = io_rdata_q;

  assign mem_we    = issue && we_q && !oor;
  assign mem_re    = issue && !we_q && !oor;
  assign mem_addr  = (issue && !oor) ? sum_q[ADDR_W-1:0] : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level model.
// Second instance covers a three-cycle read latency.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    req, we;
  logic [31:0]   addr [2];
  logic [31:0]   off [2];
  logic [DW-1:0] wdata [2];
  logic [1:0]    gnt, done, err;
  logic [DW-1:0] rdata [2];
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]),
    .cpu_off(off[0]), .cpu_wdata(wdata[0]),
    .cpu_gnt(gnt[0]), .cpu_done(done[0]), .cpu_err(err[0]),
    .cpu_rdata(rdata[0]),
    .io_req(req[1]), .io_we(we[1]), .io_addr(addr[1]),
    .io_off(off[1]), .io_wdata(wdata[1]),
    .io_gnt(gnt[1]), .io_done(done[1]), .io_err(err[1]),
    .io_rdata(rdata[1]),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory array behind the first instance, one-cycle read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Second instance: RD_LAT=3, read data driven fresh every negedge.
  logic          io2_req, io2_we;
  logic [31:0]   io2_addr, io2_off;
  logic          c2_gnt, c2_done, c2_err, io2_gnt, io2_done, io2_err;
  logic [DW-1:0] c2_rdata, io2_rdata, m2_wdata, m2_rdata;
  logic [AW-1:0] m2_addr;
  logic          m2_we, m2_re;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(32'h0),
    .cpu_off(32'h0), .cpu_wdata(32'h0),
    .cpu_gnt(c2_gnt), .cpu_done(c2_done), .cpu_err(c2_err),
    .cpu_rdata(c2_rdata),
    .io_req(io2_req), .io_we(io2_we), .io_addr(io2_addr),
    .io_off(io2_off), .io_wdata(32'h0),
    .io_gnt(io2_gnt), .io_done(io2_done), .io_err(io2_err),
    .io_rdata(io2_rdata),
    .mem_addr(m2_addr), .mem_we(m2_we), .mem_re(m2_re),
    .mem_wdata(m2_wdata), .mem_rdata(m2_rdata)
  );

  always @(negedge clk) m2_rdata = $urandom;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state: shadow memory, per-port read data, last winner.
  logic [DW-1:0] ref_mem [logic [31:0]];
  logic [DW-1:0] exp_rdata [2];
  int last_w;
  int gq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt[0]) gq.push_back(0);
      if (gnt[1]) gq.push_back(1);
      if (|gnt || |done || mem_we || mem_re)
        chk("excl", {gnt == 2'b11, done == 2'b11, mem_we & mem_re,
                     |(err & ~done)}, 0);
    end
  end

  task automatic txn(input int p, input logic w, input logic [31:0] a,
                     input logic [31:0] o, input logic [DW-1:0] d,
                     input bit solo);
    logic [31:0] s;
    bit e;
    int lat;
    int n;
    s = a + o;
    e = (s >> AW) != 0;
    we[p] = w; addr[p] = a; off[p] = o; wdata[p] = d; req[p] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!gnt[p] && n < 50);
    chk("gnt", gnt[p], 1);
    if (!gnt[p]) begin
      req[p] = 1'b0;
      return;
    end
    chk("mem_we", mem_we, w && !e);
    chk("mem_re", mem_re, !w && !e);
    if (!e) chk("mem_addr", mem_addr, s[AW-1:0]);
    if (w && !e) chk("mem_wdata", mem_wdata, d);
    last_w = p;
    if (!e) begin
      if (w) ref_mem[s] = d;
      else exp_rdata[p] = ref_mem.exists(s) ? ref_mem[s] : '0;
    end
    lat = (e || w) ? 1 : 1 + LAT1;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      chk("strobe_idle", {mem_we, mem_re}, 0);
      if (k < lat) chk("early_done", done[p], 0);
      if (solo) chk("quiet", {gnt[1-p], done[1-p], err[1-p]}, 0);
    end
    chk("done", done[p], 1);
    chk("err", err[p], e);
    chk("rdata", rdata[p], exp_rdata[p]);
    req[p] = 1'b0;
  endtask

  task automatic rand_txn(input int p, input bit solo);
    logic [31:0] s, a;
    logic w;
    w = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 4) == 0) s = $urandom | 32'h2000;
    else s = $urandom_range(0, 31);
    a = $urandom;
    txn(p, w, a, s - a, $urandom, solo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int exp_first;
    int m;
    logic [DW-1:0] cap;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    req = 0; we = 0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 0; off[i] = 0; wdata[i] = 0; exp_rdata[i] = 0;
    end
    io2_req = 0; io2_we = 0; io2_addr = 0; io2_off = 0;
    last_w = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {gnt, done, err, mem_we, mem_re}, 0);
    chk("rst_rdata", {rdata[0], rdata[1]}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Three-cycle latency read on the second instance.
    io2_req = 1'b1; io2_addr = 32'h5;
    m = 0;
    do begin
      @(posedge clk); #1; m++;
    end while (!io2_gnt && m < 20);
    chk("l3_gnt", io2_gnt, 1);
    chk("l3_re", m2_re, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("l3_wait", {m2_re, io2_done}, 0);
    end
    @(negedge clk); #1;
    cap = m2_rdata;
    @(posedge clk); #1;
    chk("l3_done", {io2_done, io2_err}, 2'b10);
    chk("l3_rdata", io2_rdata, cap);
    io2_req = 1'b0;

    // Directed cases.
    txn(0, 1, 32'h10, 32'h4, 32'hDEADBEEF, 1);
    txn(0, 0, 32'h10, 32'h4, 32'h0, 1);
    chk("rd_beef", rdata[0], 32'hDEADBEEF);
    txn(1, 0, 32'h1FFF, 32'h1, 32'h0, 1);
    txn(0, 1, 32'hFFFFFFFF, 32'h2, 32'h12345678, 1);
    txn(1, 0, 32'hFFFFFFFF, 32'h2, 32'h0, 1);
    chk("wrap_rd", rdata[1], 32'h12345678);

    // Simultaneous back-to-back requesters alternate.
    exp_first = (last_w == 1) ? 0 : 1;
    gq.delete();
    fork
      repeat (3) rand_txn(0, 0);
      repeat (3) rand_txn(1, 0);
    join
    chk("alt_n", gq.size(), 6);
    for (int i = 0; i < gq.size() && i < 6; i++)
      chk("alt", gq[i], (exp_first + i) % 2);

    // Reset in the WAIT of a CPU read.
    txn(0, 0, 32'h14, 32'h0, 32'h0, 1);
    we[0] = 0; addr[0] = 32'h14; off[0] = 0; req[0] = 1'b1;
    m = 0;
    do begin
      @(posedge clk); #1; m++;
    end while (!gnt[0] && m < 20);
    chk("pre_rst_gnt", gnt[0], 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_ctl", {gnt, done, err, mem_we, mem_re}, 0);
    chk("arst_mem", {mem_addr, mem_wdata}, 0);
    chk("arst_rd", {rdata[0], rdata[1]}, 0);
    req = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_nodone", done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_rdata[0] = 0; exp_rdata[1] = 0;
    last_w = 1;
    gq.delete();
    fork
      txn(0, 0, 32'h14, 32'h0, 32'h0, 0);
      txn(1, 0, 32'h10, 32'h4, 32'h0, 0);
    join
    chk("post_rst_first", gq.size() > 0 ? gq[0] : 9, 0);

    // Random rounds: single requesters and ties.
    for (int r = 0; r < 60; r++) begin
      m = $urandom_range(1, 3);
      if (m == 3) begin
        exp_first = (last_w == 1) ? 0 : 1;
        gq.delete();
        fork
          rand_txn(0, 0);
          rand_txn(1, 0);
        join
        chk("rr_first", gq.size() > 0 ? gq[0] : 9, exp_first);
      end else begin
        rand_txn(m - 1, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port data memory between the CPU load/store path and the I/O/display requester.
- Each requester presents a base address and an offset. The arbiter computes the effective word address, performs a bounds check, grants requesters round-robin and sequences the memory strobes.
- It returns read data with a done pulse.
- It sits between the core datapath and the memory array. Exactly one transaction is outstanding at a time.

## Interface
- ADDR_W, 13, memory word-address width (2**ADDR_W words)
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req / io_req  in  1  request, held until matching done
- cpu_we / io_we  in  1  1 = write, 0 = read
- cpu_addr / io_addr  in  32  base address
- cpu_off / io_off  in  32  offset added to base
- cpu_wdata / io_wdata  in  DATA_W  write data
- cpu_gnt / io_gnt  out  1  one-cycle pulse when transaction accepted
- cpu_done / io_done  out  1  one-cycle completion pulse
- cpu_err / io_err  out  1  valid with done: address out of range
- cpu_rdata / io_rdata  out  DATA_W  read data, registered, held until next read completion for that port
- mem_addr  out  ADDR_W  word address to memory
- mem_we / mem_re  out  1  write / read strobe
- mem_wdata  out  DATA_W  write data to memory
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_re

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is high, arbitrate and latch the winner's we/addr/off/wdata.
  - Compute sum = addr + off, modulo 2**32 (carry discarded).
  - Assert the winner's gnt and go to ISSUE.
- Arbitration:
  - A single requester wins.
  - If both request, the one not granted last wins.
  - last_winner resets to IO, so the CPU wins the first tie.
- ISSUE:
  - If sum[31:ADDR_W] != 0: no strobe, err latched, rdata unchanged, go to RESP.
  - Otherwise mem_addr = sum[ADDR_W-1:0]. A write asserts mem_we and goes to RESP. A read asserts mem_re, loads the counter with RD_LAT and goes to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the last WAIT cycle, capture mem_rdata into the owner's rdata and go to RESP.
- RESP: owner's done high (err if latched), then go to IDLE.
- Requester rules:
  - Inputs must be stable from req rise until done.
  - req must be low in the cycle after done unless a new transaction is presented.
  - A req high in IDLE is always a new transaction.
- Memory strobes and mem_* are driven only in ISSUE. They are 0 in every other state.
- done, gnt and err of the non-owning port stay 0.

## Timing
- Edge numbering: E0 is the edge at which IDLE sees req.
- Grant: gnt high in cycle E0–E1. ISSUE occupies the same cycle.
- Write: mem_we in cycle E0–E1, done in cycle E1–E2. Latency 2, back in IDLE at E2.
- Read: mem_re in cycle E0–E1, WAIT for RD_LAT cycles, data captured at E(1+RD_LAT), done in the following cycle. With RD_LAT=1, done is in E2–E3.
- Out-of-range: done+err in cycle E1–E2, with no strobe.
- Throughput: a back-to-back requester is next granted at the first IDLE edge after RESP. Minimum write spacing is 3 cycles.
- Reset (asserted any time, including mid-transaction):
  - Immediately: state = IDLE, all outputs 0 (gnt, done, err, mem_*, rdata), last_winner = IO.
  - The aborted transaction gets no done.
- Simultaneous: if one port's req rises while another transaction is in flight, that port waits. It is arbitrated at the next IDLE against any other pending request.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - requester-ID constants REQ_CPU = 0 and REQ_IO = 1;
  - the default widths.
- Sub-module rr_arb2 is the two-input round-robin arbiter. Its last_winner register updates only on an enable, which is asserted in IDLE when a grant is made.
- All counters and the FSM live in dmem_arbiter. The counter is $clog2(RD_LAT+1) bits.

## Test plan
- CPU write, addr=0x10 off=0x4, wdata=0xDEADBEEF:
  - mem_we with mem_addr=0x14 for one cycle, cpu_done 2 cycles after grant edge, io_* quiet.
  - Then CPU read of same → cpu_rdata=0xDEADBEEF with done at E2–E3.
- cpu_req and io_req rise on the same edge, both held for 3 transactions each:
  - Grants alternate CPU, IO, CPU, IO, CPU, IO.
  - No overlapping strobes.
- IO read with addr=0x1FFF off=0x1 (sum=0x2000, ADDR_W=13):
  - io_done and io_err together, mem_re never asserted, io_rdata unchanged.
- Offset wrap, addr=0xFFFFFFFF off=0x2:
  - sum=0x1, in range, mem_addr=0x1, no err.
- rst asserted during the WAIT of a CPU read:
  - All outputs 0 asynchronously, no cpu_done.
  - After release, a pending io_req + cpu_req tie grants the CPU first.
- RD_LAT=3 build, IO read:
  - mem_re for one cycle, done exactly 3 cycles after the ISSUE cycle ends.
  - io_rdata equals the mem_rdata present on the capture edge.
